// File: rtl/l1_line_mover.sv
// Line mover between the L1 data array and pmem: optional victim writeback,
// then a line fill, with a per-access pmem response timeout.
module l1_line_mover #(
    parameter int WIDTH   = 128,
    parameter int INDEX_W = 3,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wb,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [ADDR_W-1:0]  req_wb_addr,
    input  logic [ADDR_W-1:0]  req_fill_addr,
    output logic               done,
    output logic               err,
    output logic               arr_write,
    output logic [INDEX_W-1:0] arr_index,
    output logic [WIDTH-1:0]   arr_datain,
    input  logic [WIDTH-1:0]   arr_dataout,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [ADDR_W-1:0]  pmem_address,
    output logic [WIDTH-1:0]   pmem_wdata,
    input  logic [WIDTH-1:0]   pmem_rdata,
    input  logic               pmem_resp
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_MEM,
        FILL_MEM,
        FILL_WR,
        DONE_S
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   buf_q;
    logic [INDEX_W-1:0] idx_q;
    logic [ADDR_W-1:0]  wb_addr_q;
    logic [ADDR_W-1:0]  fill_addr_q;
    logic [CW-1:0]      cnt_q;
    logic               tmo;

    // A TIMEOUT of zero disables the limit entirely.
    assign tmo        = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign req_ready  = (state == IDLE);
    assign arr_index  = idx_q;
    assign arr_datain = buf_q;
    assign pmem_wdata = buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            buf_q        <= '0;
            idx_q        <= '0;
            wb_addr_q    <= '0;
            fill_addr_q  <= '0;
            cnt_q        <= '0;
            arr_write    <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            arr_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_q       <= req_index;
                        wb_addr_q   <= req_wb_addr;
                        fill_addr_q <= req_fill_addr;
                        cnt_q       <= '0;
                        if (req_wb) begin
                            state <= WB_RD;
                        end else begin
                            state        <= FILL_MEM;
                            pmem_read    <= 1'b1;
                            pmem_address <= req_fill_addr & LINE_MASK;
                        end
                    end
                end
                WB_RD: begin
                    buf_q        <= arr_dataout;
                    pmem_write   <= 1'b1;
                    pmem_address <= wb_addr_q & LINE_MASK;
                    cnt_q        <= '0;
                    state        <= WB_MEM;
                end
                WB_MEM: begin
                    if (pmem_resp) begin
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= fill_addr_q & LINE_MASK;
                        cnt_q        <= '0;
                        state        <= FILL_MEM;
                    end else if (tmo) begin
                        pmem_write <= 1'b0;
                        done       <= 1'b1;
                        err        <= 1'b1;
                        state      <= DONE_S;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FILL_MEM: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        buf_q     <= pmem_rdata;
                        arr_write <= 1'b1;
                        state     <= FILL_WR;
                    end else if (tmo) begin
                        pmem_read <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        state     <= DONE_S;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FILL_WR: begin
                    done  <= 1'b1;
                    state <= DONE_S;
                end
                DONE_S: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_line_mover.sv
// Randomized scoreboard bench for l1_line_mover, plus directed timeout and
// mid-operation reset checks on a short-timeout instance.
module tb_l1_line_mover;

    logic         clk;
    logic         rst_n;
    logic         req_valid, req_ready, req_wb;
    logic [2:0]   req_index;
    logic [15:0]  req_wb_addr, req_fill_addr;
    logic         done, err, arr_write;
    logic [2:0]   arr_index;
    logic [127:0] arr_datain, arr_dataout;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;

    logic         t_req_valid, t_req_ready, t_req_wb;
    logic [2:0]   t_req_index;
    logic [15:0]  t_req_wb_addr, t_req_fill_addr;
    logic         t_done, t_err, t_arr_write;
    logic [2:0]   t_arr_index;
    logic [127:0] t_arr_datain, t_arr_dataout;
    logic         t_pmem_read, t_pmem_write, t_pmem_resp;
    logic [15:0]  t_pmem_address;
    logic [127:0] t_pmem_wdata, t_pmem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    l1_line_mover u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_index(req_index), .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
        .done(done), .err(err),
        .arr_write(arr_write), .arr_index(arr_index),
        .arr_datain(arr_datain), .arr_dataout(arr_dataout),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    l1_line_mover #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_wb(t_req_wb),
        .req_index(t_req_index), .req_wb_addr(t_req_wb_addr), .req_fill_addr(t_req_fill_addr),
        .done(t_done), .err(t_err),
        .arr_write(t_arr_write), .arr_index(t_arr_index),
        .arr_datain(t_arr_datain), .arr_dataout(t_arr_dataout),
        .pmem_read(t_pmem_read), .pmem_write(t_pmem_write), .pmem_address(t_pmem_address),
        .pmem_wdata(t_pmem_wdata), .pmem_rdata(t_pmem_rdata), .pmem_resp(t_pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment array for the main instance, and the reference copy.
    logic [127:0] mem_arr [8];
    logic [127:0] ref_arr [8];
    assign arr_dataout   = mem_arr[arr_index];
    assign t_arr_dataout = 128'h5;
    always @(posedge clk) if (arr_write) mem_arr[arr_index] <= arr_datain;

    localparam int K_PW = 0, K_PR = 1, K_AW = 2, K_DN = 3;
    typedef struct {
        int           kind;
        logic [15:0]  addr;
        logic [127:0] data;
        int           cyc;
    } exp_t;
    exp_t expq[$];
    int           dq[$];
    logic [127:0] rq[$];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic logic [15:0] line_of(input logic [15:0] a);
        return 16'((int'(a) / 16) * 16);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // pmem responder: per access, pops a wait count and read data.
    initial begin
        bit           in_acc;
        int           wcnt, d;
        logic [127:0] rd;
        in_acc = 0; wcnt = 0; d = 0; rd = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = rnd128();
            if (!rst_n) begin
                in_acc = 0;
            end else begin
                if ((pmem_read || pmem_write) && !in_acc) begin
                    in_acc = 1; wcnt = 0;
                    if (dq.size() > 0) begin
                        d = dq.pop_front(); rd = rq.pop_front();
                    end else begin
                        d = 0; rd = '0;
                    end
                end
                if (in_acc) begin
                    if (wcnt == d) begin
                        pmem_resp = 1'b1; pmem_rdata = rd; in_acc = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    pmem_resp = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: pops expected events as the DUT presents them.
    logic ended_q = 1'b0;
    always @(posedge clk) ended_q <= pmem_resp && (pmem_read || pmem_write);

    initial begin
        bit           prev_str;
        logic [15:0]  st_addr;
        logic [127:0] st_wdata;
        exp_t         e;
        prev_str = 0; st_addr = '0; st_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_str = 0;
            end else begin
                if (pmem_read || pmem_write) begin
                    check("strobe exclusive", 256'(pmem_read && pmem_write), 256'(0));
                    if (!prev_str || ended_q) begin
                        if (expq.size() == 0) begin
                            check("unexpected pmem access", 256'(1), 256'(0));
                        end else begin
                            e = expq.pop_front();
                            check("pmem kind", 256'(pmem_write ? K_PW : K_PR), 256'(e.kind));
                            check("pmem address", 256'(pmem_address), 256'(e.addr));
                            if (pmem_write) check("pmem wdata", 256'(pmem_wdata), 256'(e.data));
                        end
                        st_addr = pmem_address; st_wdata = pmem_wdata;
                    end else begin
                        check("strobe hold stable",
                              {pmem_address, pmem_write ? pmem_wdata : 128'h0},
                              {st_addr, pmem_write ? st_wdata : 128'h0});
                    end
                end
                if (arr_write) begin
                    if (expq.size() == 0) begin
                        check("unexpected arr_write", 256'(1), 256'(0));
                    end else begin
                        e = expq.pop_front();
                        check("arr kind", 256'(K_AW), 256'(e.kind));
                        check("arr index", 256'(arr_index), 256'(e.addr));
                        check("arr datain", 256'(arr_datain), 256'(e.data));
                    end
                end
                if (done) begin
                    if (expq.size() == 0) begin
                        check("unexpected done", 256'(1), 256'(0));
                    end else begin
                        e = expq.pop_front();
                        check("done kind", 256'(K_DN), 256'(e.kind));
                        check("done cycle", 256'(cyc), 256'(e.cyc));
                        check("done err", 256'(err), 256'(0));
                    end
                end
                prev_str = pmem_read || pmem_write;
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) check("req_ready wait", 256'(0), 256'(1));
    endtask

    // Issue one request and push the reference outcome.
    task automatic issue(input bit wb, input logic [2:0] idx, input logic [15:0] wa,
                         input logic [15:0] fa, input logic [127:0] rdata,
                         input int dwb, input int dfill);
        int a;
        wait_ready();
        req_valid = 1'b1; req_wb = wb; req_index = idx;
        req_wb_addr = wa; req_fill_addr = fa;
        @(posedge clk);
        #1;
        a = cyc;
        if (wb) begin
            dq.push_back(dwb); rq.push_back(rnd128());
            expq.push_back('{K_PW, line_of(wa), ref_arr[idx], 0});
        end
        dq.push_back(dfill); rq.push_back(rdata);
        expq.push_back('{K_PR, line_of(fa), 128'h0, 0});
        expq.push_back('{K_AW, 16'(idx), rdata, 0});
        expq.push_back('{K_DN, 16'h0, 128'h0,
                         a + (wb ? 5 : 3) + (wb ? dwb : 0) + dfill - 1});
        ref_arr[idx] = rdata;
        req_valid = 1'b0;
        req_wb = 1'($urandom); req_index = 3'($urandom);
        req_wb_addr = 16'($urandom); req_fill_addr = 16'($urandom);
    endtask

    // Short-timeout instance: resp on strobe cycle dresp+1, or never if dresp<0.
    task automatic to_run(input bit wb, input int dresp);
        int n = 0;
        bit saw_aw = 0, saw_rd = 0, got_done = 0, got_err = 0;
        logic [127:0] rd = rnd128();
        logic [127:0] aw_data = '0;
        int g = 0;
        @(negedge clk);
        while (!t_req_ready && g < 50) begin @(negedge clk); g++; end
        t_req_valid = 1'b1; t_req_wb = wb; t_req_index = 3'd3;
        t_req_wb_addr = 16'h2000; t_req_fill_addr = 16'h3004;
        @(posedge clk);
        #1;
        t_req_valid = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(negedge clk);
            t_pmem_resp = 1'b0;
            if (t_pmem_read) saw_rd = 1;
            if (t_pmem_read || t_pmem_write) begin
                n++;
                if (dresp >= 0 && n == dresp + 1) begin
                    t_pmem_resp = 1'b1; t_pmem_rdata = rd;
                end
            end
            if (t_arr_write) begin saw_aw = 1; aw_data = t_arr_datain; end
            if (t_done) begin got_done = 1; got_err = t_err; end
        end
        t_pmem_resp = 1'b0;
        check("timeout done seen", 256'(got_done), 256'(1));
        if (dresp < 0) begin
            check("timeout strobe cycles", 256'(n), 256'(4));
            check("timeout err", 256'(got_err), 256'(1));
            check("timeout no arr_write", 256'(saw_aw), 256'(0));
            if (wb) check("timeout wb skips fill", 256'(saw_rd), 256'(0));
        end else begin
            check("resp beats timeout strobes", 256'(n), 256'(dresp + 1));
            check("resp beats timeout err", 256'(got_err), 256'(0));
            check("resp beats timeout write", {127'h0, saw_aw, aw_data}, {127'h0, 1'b1, rd});
        end
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        req_valid = 0; req_wb = 0; req_index = 0; req_wb_addr = 0; req_fill_addr = 0;
        t_req_valid = 0; t_req_wb = 0; t_req_index = 0; t_req_wb_addr = 0; t_req_fill_addr = 0;
        t_pmem_resp = 0; t_pmem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            mem_arr[i] = rnd128();
            ref_arr[i] = mem_arr[i];
        end
        mem_arr[2] = {4{32'hDEADBEEF}};
        ref_arr[2] = mem_arr[2];

        repeat (2) @(negedge clk);
        check("reset req_ready", 256'(req_ready), 256'(1));
        check("reset strobes/done/err/arr_write",
              256'({pmem_read, pmem_write, done, err, arr_write}), 256'(0));
        check("reset arr_index/pmem_address", 256'({arr_index, pmem_address}), 256'(0));
        check("reset buffer", 256'(arr_datain), 256'(0));
        rst_n = 1'b1;

        issue(1'b0, 3'd5, 16'h0000, 16'h1237, {16{8'hA5}}, 0, 0);
        issue(1'b1, 3'd2, 16'h4000, 16'h8010, rnd128(), 0, 0);
        issue(1'b1, 3'd6, 16'h5a5f, 16'h0123, rnd128(), 10, 10);
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                  rnd128(), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        g = 0;
        while (expq.size() != 0 && g < 500) begin @(negedge clk); g++; end
        check("scoreboard drained", 256'(expq.size()), 256'(0));
        for (int i = 0; i < 8; i++) check("array contents", mem_arr[i], ref_arr[i]);

        to_run(1'b0, -1);
        to_run(1'b1, -1);
        to_run(1'b0, 3);

        // Reset in the middle of a long fill.
        wait_ready();
        req_valid = 1'b1; req_wb = 1'b0; req_index = 3'd6; req_fill_addr = 16'h7777;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dq.push_back(40); rq.push_back(rnd128());
        expq.push_back('{K_PR, 16'h7770, 128'h0, 0});
        repeat (3) @(negedge clk);
        check("fill in progress", 256'(pmem_read), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async reset strobes", 256'({pmem_read, pmem_write, arr_write, done}), 256'(0));
        check("async reset regs", 256'({req_ready, arr_index, pmem_address}), 256'({1'b1, 19'h0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("after reset idle", 256'({req_ready, pmem_read, pmem_write}), 256'(3'b100));
        check("reset test drained", 256'(expq.size()), 256'(0));
        for (int i = 0; i < 8; i++) check("array untouched by reset", mem_arr[i], ref_arr[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
